instruction_fetcher: RTL

- Instruction fetch stage feeding the core controller. The controller hands over a PC and waits for a completion flag before it decodes the returned instruction word.
- Contains a direct-mapped, one-word-per-line instruction cache in front of a request/valid instruction-memory port.
- Runs only while `fetcher_reset` is low. The controller holds `fetcher_reset` high outside its FETCH state.

---
 rtl/instruction_fetcher_if.sv | 24 ++
 rtl/instruction_fetcher.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instruction_fetcher_if.sv
// Instruction-memory read port shared by the fetcher and the memory.
//   master (fetcher side): drives mem_req / mem_addr, receives mem_valid / mem_data
//   slave  (memory side) : receives mem_req / mem_addr, drives mem_valid / mem_data
// mem_valid is only meaningful while mem_req is high.
interface instruction_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_valid,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_valid,
        output mem_data
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line cache.
// The controller presents a PC and lowers fetcher_reset; the stage looks
// the word up in the cache, fetches it from instruction memory on a miss,
// and raises fetcher_completed with the word on instruction.
//   clk, reset        : clock and synchronous active-high reset
//   fetcher_reset     : high = idle / abandon, low = fetch pc
//   pc                : byte address, bits [1:0] ignored
//   fetcher_completed : instruction is valid for the latched PC
//   instruction       : fetched instruction word
//   mem               : instruction-memory read port (master side)
module instruction_fetcher #(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetcher_reset,
    input  logic [31:0]           pc,
    output logic                  fetcher_completed,
    output logic [31:0]           instruction,
    instruction_fetcher_if.master mem
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, DONE, DRAIN} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [29:0]           lpc_q;
    logic [31:0]           instruction_q;
    logic                  completed_q;
    logic                  mem_req_q;
    logic [31:0]           mem_addr_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   lpc_tag;
    logic                  hit;
    logic                  fill;
    logic                  unused_pc_bits;

    // Only the word address is kept; the byte offset is deliberately dropped.
    assign unused_pc_bits = ^pc[1:0];

    assign index   = lpc_q[INDEX_BITS-1:0];
    assign lpc_tag = lpc_q[29:INDEX_BITS];
    assign hit     = valid_q[index] && (tag_mem[index] == lpc_tag);

    // A pending read completes in MISS or DRAIN alike; DRAIN exists so an
    // abandoned miss still fills its line before a new fetch can start.
    assign fill = ((state_q == MISS) || (state_q == DRAIN)) && mem.mem_valid;

    assign fetcher_completed = completed_q;
    assign instruction       = instruction_q;
    assign mem.mem_req       = mem_req_q;
    assign mem.mem_addr      = mem_addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fetcher_reset) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (fetcher_reset) state_d = IDLE;
                else if (hit)      state_d = DONE;
                else               state_d = MISS;
            end
            MISS: begin
                if (mem.mem_valid)      state_d = fetcher_reset ? IDLE : DONE;
                else if (fetcher_reset) state_d = DRAIN;
            end
            DRAIN: begin
                if (mem.mem_valid) state_d = IDLE;
            end
            DONE: begin
                if (fetcher_reset) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath. Outputs are derived from the next
    // state so completion and request flags line up with the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            lpc_q         <= '0;
            instruction_q <= '0;
            completed_q   <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            valid_q       <= '0;
        end else begin
            completed_q <= (state_d == DONE);
            mem_req_q   <= (state_d == MISS) || (state_d == DRAIN);
            if ((state_q == IDLE) && !fetcher_reset) begin
                lpc_q <= pc[31:2];
            end
            if ((state_q == LOOKUP) && (state_d == MISS)) begin
                mem_addr_q <= {lpc_q, 2'b00};
            end
            if ((state_q == LOOKUP) && (state_d == DONE)) begin
                instruction_q <= data_mem[index];
            end
            if ((state_q == MISS) && (state_d == DONE)) begin
                instruction_q <= mem.mem_data;
            end
            if (fill) begin
                valid_q[index] <= 1'b1;
            end
        end
    end

    // Cache payload; contents are meaningless until the valid bit is set,
    // so these arrays need no reset.
    always_ff @(posedge clk) begin
        if (fill && !reset) begin
            data_mem[index] <= mem.mem_data;
            tag_mem[index]  <= lpc_tag;
        end
    end
endmodule
